instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/mips_pkg.sv | 36 +++
 rtl/if_id_reg.sv | 39 +++
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS front end: reset/NOP values, fetch FSM
// encoding, opcodes used by the control unit, and small PC helpers.
package mips_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Fetch state encoding; kept as plain constants so older RTL can reuse it.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  // Instruction fetches are always word aligned; the low bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Wraps modulo 2^32, so 32'hFFFF_FFFC advances to 32'h0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a NOP bubble, hold freezes it,
// otherwise it loads the presented instruction and its PC+4.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc4_d,
  output logic [31:0] instr_q,
  output logic [31:0] pc4_q,
  output logic        valid_q
);

  if_id_t r;

  // Flush wins over hold; a bubble keeps the last pc4 since valid=0 marks it stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      r.instr <= NOP_INSTR;
      r.pc4   <= 32'h0;
      r.valid <= 1'b0;
    end else if (flush) begin
      r.instr <= NOP_INSTR;
      r.valid <= 1'b0;
    end else if (!hold) begin
      r.instr <= instr_d;
      r.pc4   <= pc4_d;
      r.valid <= 1'b1;
    end
  end

  assign instr_q = r.instr;
  assign pc4_q   = r.pc4;
  assign valid_q = r.valid;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC sequencing, memory request FSM, stall buffer,
// branch redirect and the IF/ID register feeding decode.
module instr_fetch_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  opcode,
  output logic        misalign_err,
  output logic [1:0]  fsm_state
);

  // Memory handshake: a word transfers on a cycle where imem_req and
  // imem_ready are both high; imem_addr stays stable until that happens.
  // imem_ready is ignored whenever imem_req is low.

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] buffer;

  logic        in_fetch;
  logic        in_hold;
  logic        redirect;
  logic        accept;
  logic        load_en;
  logic        flush;
  logic        hold;
  logic [31:0] load_instr;
  logic [31:0] pc_next4;

  assign in_fetch = (state == ST_FETCH);
  assign in_hold  = (state == ST_HOLD);
  assign redirect = branch_taken && (in_fetch || in_hold);
  assign accept   = in_fetch && imem_ready;
  assign pc_next4 = pc_plus4(pc);

  always_comb begin
    load_en    = 1'b0;
    flush      = 1'b0;
    load_instr = imem_rdata;
    if (redirect) begin
      flush = 1'b1;
    end else if (in_fetch && !stall) begin
      if (imem_ready) load_en = 1'b1;
      else            flush   = 1'b1;
    end else if (in_hold && !stall) begin
      load_en    = 1'b1;
      load_instr = buffer;
    end
  end

  assign hold = !load_en && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      pc     <= RESET_PC;
      buffer <= NOP_INSTR;
    end else begin
      case (state)
        ST_IDLE: state <= ST_FETCH;
        ST_FETCH: begin
          if (redirect) begin
            pc     <= word_align(branch_target);
            buffer <= NOP_INSTR;
          end else if (accept && !stall) begin
            pc <= pc_next4;
          end else if (accept && stall) begin
            buffer <= imem_rdata;
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            pc     <= word_align(branch_target);
            buffer <= NOP_INSTR;
            state  <= ST_FETCH;
          end else if (!stall) begin
            pc     <= pc_next4;
            buffer <= NOP_INSTR;
            state  <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky until reset; a redirect ignored in IDLE cannot raise it.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (redirect && (branch_target[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .hold    (hold),
    .flush   (flush),
    .instr_d (load_instr),
    .pc4_d   (pc_next4),
    .instr_q (if_id_instr),
    .pc4_q   (if_id_pc4),
    .valid_q (if_id_valid)
  );

  assign imem_req  = in_fetch;
  assign imem_addr = pc;
  assign opcode    = if_id_instr[31:26];
  assign fsm_state = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized traffic compared cycle by cycle with a behavioural fetch model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  opcode;
  logic        misalign_err;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .opcode        (opcode),
    .misalign_err  (misalign_err),
    .fsm_state     (fsm_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Behavioural model: next fetch address, a one-cycle post-reset warm-up,
  // words accepted but not yet presented (exp_q), and the expected IF/ID view.
  logic [31:0] m_pc;
  logic        m_warm;
  logic [31:0] exp_q[$];
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_mis;

  function automatic logic m_req();
    return !m_warm && (exp_q.size() == 0);
  endfunction

  // Driver: apply one cycle of inputs, advance the model at the edge, sample #1 later.
  task automatic step(input logic r, input logic s, input logic b,
                      input logic [31:0] t, input logic rdy, input logic [31:0] d);
    rst = r; stall = s; branch_taken = b; branch_target = t;
    imem_ready = rdy; imem_rdata = d;
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_warm = 1'b1; exp_q.delete();
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
    end else if (m_warm) begin
      m_warm = 1'b0;
    end else if (b) begin
      if (t[1:0] != 2'b00) m_mis = 1'b1;
      m_pc = t & 32'hFFFF_FFFC;
      exp_q.delete();
      m_instr = 32'h0; m_valid = 1'b0;
    end else if (exp_q.size() > 0) begin
      if (!s) begin
        m_instr = exp_q.pop_front(); m_pc4 = m_pc + 32'd4;
        m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end
    end else if (rdy) begin
      if (s) exp_q.push_back(d);
      else begin
        m_instr = d; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end
    end else if (!s) begin
      m_instr = 32'h0; m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic idle_cycle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++;
    if ({if_id_instr, if_id_pc4, if_id_valid} !== 65'h0) begin
      errors++; $display("FAIL reset_ifid got instr=%h pc4=%h valid=%b exp all 0", if_id_instr, if_id_pc4, if_id_valid);
    end
    checks++;
    if (opcode !== 6'h0 || misalign_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags got opcode=%h mis=%b exp 0/0", opcode, misalign_err);
    end
    idle_cycle();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_first_fetch got req=%b addr=%h exp 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] words [3] = '{32'h8C00_0000, 32'hAC00_0000, 32'h1000_0000};
    logic [5:0]  ops   [3] = '{6'h23, 6'h2B, 6'h04};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, words[i]);
      checks++;
      if (if_id_pc4 !== 32'(4 * (i + 1)) || opcode !== ops[i] || if_id_valid !== 1'b1 ||
          if_id_instr !== words[i]) begin
        errors++;
        $display("FAIL stream_%0d got pc4=%h op=%h valid=%b instr=%h exp pc4=%h op=%h valid=1 instr=%h",
                 i, if_id_pc4, opcode, if_id_valid, if_id_instr, 32'(4 * (i + 1)), ops[i], words[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle_cycle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2008_0001);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2008_0002);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hBAD0_0000);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
        errors++;
        $display("FAIL wait_%0d got req=%b addr=%h valid=%b instr=%h exp 1/8/0/0",
                 i, imem_req, imem_addr, if_id_valid, if_id_instr);
      end
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0020);
    checks++;
    if (if_id_pc4 !== 32'hC || if_id_instr !== 32'h0000_0020 || if_id_valid !== 1'b1) begin
      errors++; $display("FAIL wait_deliver got pc4=%h instr=%h valid=%b exp c/00000020/1",
                         if_id_pc4, if_id_instr, if_id_valid);
    end
  endtask

  task automatic test_stall_data();
    // Continues at pc=12 with IF/ID holding pc4=12, instr=0x20
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8C01_0004);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (imem_req !== 1'b0 || if_id_pc4 !== 32'hC || if_id_instr !== 32'h0000_0020 || if_id_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d got req=%b pc4=%h instr=%h valid=%b exp 0/c/00000020/1",
                 i, imem_req, if_id_pc4, if_id_instr, if_id_valid);
      end
      if (i == 0) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_0000);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (if_id_instr !== 32'h8C01_0004 || if_id_pc4 !== 32'h10 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL stall_release got instr=%h pc4=%h req=%b addr=%h exp 8c010004/10/1/10",
               if_id_instr, if_id_pc4, imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_over_stall();
    step(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
      errors++;
      $display("FAIL branch_redirect got req=%b addr=%h valid=%b instr=%h exp 1/40/0/0",
               imem_req, imem_addr, if_id_valid, if_id_instr);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2010_0007);
    checks++;
    if (if_id_instr !== 32'h2010_0007 || if_id_pc4 !== 32'h44 || misalign_err !== 1'b0) begin
      errors++; $display("FAIL branch_next got instr=%h pc4=%h mis=%b exp 20100007/44/0",
                         if_id_instr, if_id_pc4, misalign_err);
    end
  endtask

  task automatic test_misalign();
    step(1'b0, 1'b0, 1'b1, 32'h43, 1'b0, 32'h0);
    checks++;
    if (imem_addr !== 32'h40 || misalign_err !== 1'b1) begin
      errors++; $display("FAIL misalign_set got addr=%h mis=%b exp 40/1", imem_addr, misalign_err);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0000);
    step(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    checks++;
    if (misalign_err !== 1'b1 || imem_addr !== 32'h80) begin
      errors++; $display("FAIL misalign_sticky got mis=%b addr=%h exp 1/80", misalign_err, imem_addr);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0123_4567);
    checks++;
    if (imem_addr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_instr !== 32'h0123_4567) begin
      errors++; $display("FAIL pc_wrap got addr=%h pc4=%h instr=%h exp 0/0/01234567",
                         imem_addr, if_id_pc4, if_id_instr);
    end
  endtask

  task automatic test_reset_mid_wait();
    step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hAC22_0000);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b0 ||
        opcode !== 6'h0 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_wait got req=%b instr=%h pc4=%h valid=%b op=%h mis=%b exp all 0",
               imem_req, if_id_instr, if_id_pc4, if_id_valid, opcode, misalign_err);
    end
    step(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h1111_1111);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL rst_first_req got req=%b addr=%h valid=%b exp 1/0/0",
                         imem_req, imem_addr, if_id_valid);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 3000; n++) begin
      logic        r, s, b, rdy;
      logic [31:0] t;
      r   = ($urandom_range(0, 149) == 0);
      s   = ($urandom_range(0, 2) == 0);
      b   = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      t   = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      step(r, s, b, t, rdy, $urandom);
      checks++;
      if (imem_req !== m_req() || (m_req() && imem_addr !== m_pc) ||
          if_id_instr !== m_instr || if_id_pc4 !== m_pc4 || if_id_valid !== m_valid ||
          opcode !== m_instr[31:26] || misalign_err !== m_mis) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_%0d got req=%b addr=%h instr=%h pc4=%h valid=%b mis=%b exp req=%b addr=%h instr=%h pc4=%h valid=%b mis=%b",
                   n, imem_req, imem_addr, if_id_instr, if_id_pc4, if_id_valid, misalign_err,
                   m_req(), m_pc, m_instr, m_pc4, m_valid, m_mis);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_wait_states();
    test_stall_data();
    test_branch_over_stall();
    test_misalign();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
